// File: rtl/counter_alarm.sv
// counter_alarm: match alarm on a free-running counter, one-shot or periodic, with ack and missed-event count.
// Optional COUNTER_ALARM_CAPTURE_EN: capture_o registers count_i at every match.
module counter_alarm #(
    parameter int WIDTH  = 32,
    parameter int MISS_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  count_i,
    input  logic              cfg_valid_i,
    output logic              cfg_ready_o,
    input  logic [WIDTH-1:0]  cfg_target_i,
    input  logic [WIDTH-1:0]  cfg_period_i,
    input  logic              cfg_periodic_i,
    input  logic              disarm_i,
    output logic              irq_o,
    input  logic              irq_ack_i,
    output logic [MISS_W-1:0] miss_cnt_o,
    output logic [1:0]        state_o,
    output logic [WIDTH-1:0]  capture_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, FIRED = 2'd2} state_t;
    state_t state, state_d;
    logic [WIDTH-1:0] target, target_d, period, period_d, diff;
    logic [MISS_W-1:0] miss_d;
    logic periodic, periodic_d, irq_d, match;
    assign cfg_ready_o = state == IDLE;
    assign state_o = state;
    assign diff = count_i - target;
    // wrap-safe: at or past target within half the counter range
    assign match = state == ARMED && !diff[WIDTH-1];
    always_comb begin
        state_d = state;
        target_d = target;
        period_d = period;
        periodic_d = periodic;
        irq_d = irq_o;
        miss_d = miss_cnt_o;
        if (disarm_i) begin
            state_d = IDLE;
            irq_d = 1'b0;
        end else if (cfg_valid_i && cfg_ready_o) begin
            target_d = cfg_target_i;
            period_d = cfg_period_i;
            periodic_d = cfg_periodic_i && cfg_period_i != '0;
            miss_d = '0;
            state_d = ARMED;
        end else if (match) begin
            irq_d = 1'b1;
            if (!periodic) begin
                state_d = FIRED;
            end else begin
                target_d = target + period;
                if (irq_o && !irq_ack_i && miss_cnt_o != '1)
                    miss_d = miss_cnt_o + MISS_W'(1);
            end
        end else if (irq_o && irq_ack_i) begin
            irq_d = 1'b0;
            if (state == FIRED) state_d = IDLE;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            target <= '0;
            period <= '0;
            periodic <= 1'b0;
            irq_o <= 1'b0;
            miss_cnt_o <= '0;
        end else begin
            state <= state_d;
            target <= target_d;
            period <= period_d;
            periodic <= periodic_d;
            irq_o <= irq_d;
            miss_cnt_o <= miss_d;
        end
    end
`ifdef COUNTER_ALARM_CAPTURE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) capture_o <= '0;
        else if (match && !disarm_i) capture_o <= count_i;
    end
`else
    assign capture_o = '0;
`endif
endmodule

// File: tb/tb_counter_alarm.sv
// tb_counter_alarm: directed and random stimulus against a behavioural alarm model.
module tb_counter_alarm;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [31:0] count_i = '0, cfg_target_i = '0, cfg_period_i = '0, capture_o;
    logic cfg_valid_i = 1'b0, cfg_periodic_i = 1'b0, disarm_i = 1'b0, irq_ack_i = 1'b0;
    logic cfg_ready_o, irq_o;
    logic [7:0] miss_cnt_o;
    logic [1:0] state_o;
    int total = 0, bad = 0, rises = 0;
    int m_st, m_miss;
    logic [31:0] m_tgt, m_per, m_cap;
    bit m_perd, m_irq;

    counter_alarm dut (
        .clk(clk), .rst_n(rst_n), .count_i(count_i), .cfg_valid_i(cfg_valid_i),
        .cfg_ready_o(cfg_ready_o), .cfg_target_i(cfg_target_i), .cfg_period_i(cfg_period_i),
        .cfg_periodic_i(cfg_periodic_i), .disarm_i(disarm_i), .irq_o(irq_o),
        .irq_ack_i(irq_ack_i), .miss_cnt_o(miss_cnt_o), .state_o(state_o), .capture_o(capture_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic mreset();
        m_st = 0; m_miss = 0; m_tgt = '0; m_per = '0; m_cap = '0; m_perd = 0; m_irq = 0;
    endtask

    // Alarm rules applied to the inputs seen at a clock edge; states 0/1/2 = idle/armed/fired.
    task automatic model();
        if (disarm_i) begin
            m_st = 0; m_irq = 0;
        end else if (m_st == 0 && cfg_valid_i) begin
            m_tgt = cfg_target_i; m_per = cfg_period_i;
            m_perd = cfg_periodic_i && cfg_period_i != 0;
            m_st = 1; m_miss = 0;
        end else if (m_st == 1 && (count_i - m_tgt) < 32'h8000_0000) begin
            m_cap = count_i;
            if (!m_perd) begin
                m_irq = 1; m_st = 2;
            end else begin
                if (m_irq && !irq_ack_i) m_miss = m_miss < 255 ? m_miss + 1 : 255;
                m_irq = 1;
                m_tgt = m_tgt + m_per;
            end
        end else if (m_irq && irq_ack_i) begin
            m_irq = 0;
            if (m_st == 2) m_st = 0;
        end
    endtask

    function automatic logic [31:0] exp_cap();
`ifdef COUNTER_ALARM_CAPTURE_EN
        return m_cap;
`else
        return 32'h0;
`endif
    endfunction

    task automatic step();
        bit prev;
        prev = irq_o;
        @(posedge clk);
        model();
        #1;
        chk("irq", 32'(irq_o), 32'(m_irq));
        chk("state", 32'(state_o), 32'(m_st));
        chk("miss", 32'(miss_cnt_o), 32'(m_miss));
        chk("ready", 32'(cfg_ready_o), 32'(m_st == 0));
        chk("capture", capture_o, exp_cap());
        if (irq_o && !prev) rises++;
        cfg_valid_i = 0; disarm_i = 0; irq_ack_i = 0;
    endtask

    task automatic cfg(input logic [31:0] tgt, input logic [31:0] per, input bit perd);
        cfg_valid_i = 1; cfg_target_i = tgt; cfg_period_i = per; cfg_periodic_i = perd;
        step();
    endtask

    task automatic disarm();
        disarm_i = 1;
        step();
    endtask

    initial begin
        mreset();
        #12;
        chk("rst_irq", 32'(irq_o), 0);
        chk("rst_state", 32'(state_o), 0);
        chk("rst_miss", 32'(miss_cnt_o), 0);
        chk("rst_cap", capture_o, 0);
        chk("rst_ready", 32'(cfg_ready_o), 1);
        @(negedge clk); rst_n = 1;
        // one-shot at 0x10
        count_i = 32'h0C;
        cfg(32'h10, 32'h0, 0);
        for (int c = 'h0D; c <= 'h10; c++) begin
            count_i = 32'(c);
            step();
        end
        chk("os_irq", 32'(irq_o), 1);
        chk("os_state", 32'(state_o), 2);
        count_i = 32'h11; irq_ack_i = 1;
        step();
        chk("os_ack_irq", 32'(irq_o), 0);
        chk("os_ack_ready", 32'(cfg_ready_o), 1);
        // periodic, prompt ack
        count_i = 32'hF0;
        cfg(32'h100, 32'h40, 1);
        rises = 0;
        for (int c = 'hF1; c <= 'h19F; c++) begin
            count_i = 32'(c); irq_ack_i = m_irq;
            step();
        end
        chk("per_rises", 32'(rises), 3);
        chk("per_miss", 32'(miss_cnt_o), 0);
        disarm();
        // periodic, never acked: miss count saturates
        count_i = 32'h0F;
        cfg(32'h10, 32'h1, 1);
        for (int c = 'h10; c < 'h10 + 300; c++) begin
            count_i = 32'(c);
            step();
        end
        chk("sat_irq", 32'(irq_o), 1);
        chk("sat_miss", 32'(miss_cnt_o), 255);
        disarm();
        chk("disarm_hold_miss", 32'(miss_cnt_o), 255);
        // wrap across 0xFFFF_FFFF
        count_i = 32'hFFFF_FFE4;
        cfg(32'hFFFF_FFF0, 32'h20, 1);
        chk("cfg_clears_miss", 32'(miss_cnt_o), 0);
        rises = 0;
        for (int k = 0; k < 12; k++) begin
            count_i = count_i + 32'd4; irq_ack_i = m_irq;
            step();
        end
        chk("wrap_rises", 32'(rises), 2);
        disarm();
        // disarm wins over a coincident match
        count_i = 32'h40;
        cfg(32'h50, 32'h0, 0);
        count_i = 32'h50; disarm_i = 1;
        step();
        chk("disarm_irq", 32'(irq_o), 0);
        chk("disarm_state", 32'(state_o), 0);
        // config request while armed is ignored
        count_i = 32'h60;
        cfg(32'h80, 32'h5, 1);
        cfg_valid_i = 1; cfg_target_i = 32'h10; cfg_period_i = 32'h1; cfg_periodic_i = 0;
        #1 chk("armed_ready", 32'(cfg_ready_o), 0);
        step();
        count_i = 32'h70;
        step();
        chk("armed_cfg_ignored", 32'(irq_o), 0);
        count_i = 32'h80;
        step();
        chk("armed_orig_target", 32'(irq_o), 1);
        disarm();
        // jump past target
        count_i = 32'h05;
        cfg(32'h20, 32'h0, 0);
        step();
        count_i = 32'h30;
        step();
        chk("jump_irq", 32'(irq_o), 1);
`ifdef COUNTER_ALARM_CAPTURE_EN
        chk("jump_cap", capture_o, 32'h30);
`else
        chk("jump_cap", capture_o, 32'h0);
`endif
        disarm();
        // random traffic with a mid-run async reset
        for (int i = 0; i < 3000; i++) begin
            count_i = count_i + $urandom_range(0, 3);
            if ($urandom_range(0, 99) < 2) count_i = count_i + $urandom;
            cfg_valid_i = $urandom_range(0, 9) == 0;
            cfg_target_i = count_i + $urandom_range(0, 40) - 32'd8;
            cfg_period_i = $urandom_range(0, 12);
            cfg_periodic_i = 1'($urandom);
            disarm_i = $urandom_range(0, 59) == 0;
            irq_ack_i = $urandom_range(0, 3) == 0;
            if (i == 1500) begin
                #2 rst_n = 0;
                #1;
                mreset();
                chk("arst_irq", 32'(irq_o), 0);
                chk("arst_state", 32'(state_o), 0);
                chk("arst_miss", 32'(miss_cnt_o), 0);
                chk("arst_cap", capture_o, 0);
                @(negedge clk) rst_n = 1;
            end
            step();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/counter_alarm.md
Name: counter_alarm

Overview:
- Downstream consumer of the free-running 32-bit counter (counter enable / value output pair).
- Compares the counter value against a programmed target and raises a level interrupt on a match.
- Supports one-shot and periodic (auto-reload) modes, with an ack handshake and a saturating missed-event count.
- Sits between the counter and the interrupt controller.

Parameters:
- WIDTH, 32, width of the counter value, target and period.
- MISS_W, 8, width of the saturating missed-event counter.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- count_i  input  WIDTH  current counter value from the upstream counter
- cfg_valid_i  input  1  configuration request
- cfg_ready_o  output  1  configuration accepted this cycle when high together with cfg_valid_i
- cfg_target_i  input  WIDTH  first match value
- cfg_period_i  input  WIDTH  reload increment, periodic mode only
- cfg_periodic_i  input  1  1 = periodic mode, 0 = one-shot
- disarm_i  input  1  abort: return to IDLE and clear the interrupt
- irq_o  output  1  interrupt pending, level
- irq_ack_i  input  1  interrupt acknowledge
- miss_cnt_o  output  MISS_W  matches that occurred while irq_o was already high
- state_o  output  2  FSM state: 0 = IDLE, 1 = ARMED, 2 = FIRED
- capture_o  output  WIDTH  count_i sampled at the last match (see Optional Feature)

Behaviour:
- Reset: state IDLE; irq_o=0; miss_cnt_o=0; capture_o=0; internal target, period and mode registers = 0.
- cfg_ready_o = (state==IDLE); it is combinational from state only.
- Config handshake: cfg_valid_i & cfg_ready_o latches target, period and mode. Next cycle: state ARMED, miss_cnt_o cleared to 0.
- Periodic mode with cfg_period_i==0 is latched as one-shot.
- Match condition (wrap-safe): MSB of (count_i - target) mod 2^WIDTH == 0, i.e. the counter is at or past the target within half the range. Evaluated only in ARMED.
- ARMED, match, one-shot:
  - Next cycle: irq_o=1, state FIRED.
  - Latency is 1 clk from the count_i value that satisfies the match to irq_o high.
- ARMED, match, periodic:
  - target <= target + period (mod 2^WIDTH); state stays ARMED.
  - If irq_o is already high and irq_ack_i is low that cycle: miss_cnt_o increments, saturating at all-ones; irq_o stays 1.
  - Otherwise: irq_o=1 next cycle.
- irq_ack_i while irq_o==1 and no new match: irq_o=0 next cycle.
  - In FIRED (one-shot), the ack also moves state to IDLE.
- irq_ack_i while irq_o==0: ignored.
- Ack and periodic match in the same cycle: irq_o stays 1 (the new event) and miss_cnt_o is unchanged.
- Catch-up: if the reloaded target is still behind count_i, a match occurs again the next cycle, once per cycle until target passes count_i.
- disarm_i (any state):
  - Next cycle: state IDLE, irq_o=0. miss_cnt_o holds its value until the next config.
  - disarm_i has priority over a match and over the config handshake in the same cycle.
- cfg_valid_i outside IDLE: not accepted; upstream holds the request until ready.
- Async reset mid-operation returns all state to reset values immediately. No match is evaluated in the first cycle after reset release, because the state is IDLE.

Optional Feature:
- Macro: COUNTER_ALARM_CAPTURE_EN.
- Defined: every match (one-shot or periodic) registers count_i into capture_o in the same edge that sets irq_o. capture_o holds until the next match or reset; disarm does not clear it.
- Not defined: the capture register is not instantiated and capture_o is tied to 0.

Test Plan:
- Reset, then config target=0x10, one-shot; ramp count_i from 0x0C by 1 per clk -> irq_o rises the cycle after count_i==0x10; state_o=2; ack -> irq_o=0, state_o=0, cfg_ready_o=1.
- Periodic target=0x100, period=0x40, ack promptly each time -> irq pulses after count 0x100, 0x140, 0x180; miss_cnt_o stays 0.
- Periodic target=0x10, period=1, count incrementing every clk, never ack -> irq_o stays 1; miss_cnt_o counts up to 0xFF and stays 0xFF.
- Wrap: target=0xFFFF_FFF0, period=0x20, count crossing 0xFFFF_FFFF -> match at 0xFFFF_FFF0, next target 0x0000_0010 matches after wrap; no spurious match at count 0x0000_0000.
- disarm_i asserted in the same cycle as count_i==target -> no irq_o, state_o=0; cfg_valid_i asserted in ARMED -> cfg_ready_o=0 and config registers unchanged.
- With COUNTER_ALARM_CAPTURE_EN, count_i jumping from 0x05 to 0x30 past target 0x20 -> irq_o=1 and capture_o=0x30. Without the macro -> capture_o=0.
